// File: rtl/test_status_dev.sv
// Memory-mapped test-status slave: latches pass/fail codes from firmware, counts cycles and
// raises a watchdog timeout. Optional `halt` input enabled by defining TEST_STATUS_HALT_EN.
module test_status_dev #(
  parameter logic [29:0] BASE_ADDR  = 30'h800,
  parameter int unsigned MAX_CYCLES = 10000,
  parameter logic [31:0] PASS_CODE  = 32'h55,
  parameter logic [31:0] FAIL_CODE  = 32'haa,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [29:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           we,
`ifdef TEST_STATUS_HALT_EN
  input  logic                 halt,
`endif
  input  logic                 re,
  output logic [31:0]          rdata,
  output logic                 sel,
  output logic [2:0]           state,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          code,
  output logic [31:0]          test_id,
  output logic [CNT_WIDTH-1:0] cycles
);

  localparam logic [2:0] S_RUNNING = 3'd0;
  localparam logic [2:0] S_PASSED  = 3'd1;
  localparam logic [2:0] S_FAILED  = 3'd2;
  localparam logic [2:0] S_ERROR   = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;
  localparam logic [2:0] S_HALTED  = 3'd5;

  logic [2:0]           r_state;
  logic [31:0]          r_code;
  logic [31:0]          r_test_id;
  logic [CNT_WIDTH-1:0] r_cycles;
  logic [31:0]          r_rdata;

  logic [29:0] w_offset;
  logic        w_wr_full;
  logic        w_wr_status;
  logic        w_wr_testid;
  logic        w_running;
  logic        w_accept_status;
  logic        w_halt;
  logic        w_timeout;
  logic [31:0] w_cycles_ext;
  logic [2:0]  w_state_nxt;
  logic [31:0] w_rdata_nxt;

`ifdef TEST_STATUS_HALT_EN
  assign w_halt = halt;
`else
  assign w_halt = 1'b0;
`endif

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the 4-word window.
  assign w_offset    = addr - BASE_ADDR;
  assign sel         = (w_offset < 30'd4);
  assign w_wr_full   = sel && (we == 4'b1111);
  assign w_wr_status = w_wr_full && (w_offset[1:0] == 2'd0);
  assign w_wr_testid = w_wr_full && (w_offset[1:0] == 2'd1);
  assign w_running   = (r_state == S_RUNNING);

  // A zero STATUS write is a no-op and must not mask a same-cycle halt or timeout.
  assign w_accept_status = w_running && w_wr_status && (wdata != 32'd0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_cycles_ext = '0;
    w_cycles_ext[CNT_WIDTH-1:0] = r_cycles;
  end

  assign w_timeout = (MAX_CYCLES != 0) && (w_cycles_ext == 32'(MAX_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept_status) begin
      if (wdata == PASS_CODE)      w_state_nxt = S_PASSED;
      else if (wdata == FAIL_CODE) w_state_nxt = S_FAILED;
      else                         w_state_nxt = S_ERROR;
    end else if (w_running && w_halt) begin
      w_state_nxt = S_HALTED;
    end else if (w_running && w_timeout) begin
      w_state_nxt = S_TIMEOUT;
    end
  end

  // Read mux uses current register values, so a same-cycle write returns pre-write data.
  always_comb begin
    w_rdata_nxt = 32'd0;
    if (re && sel) begin
      case (w_offset[1:0])
        2'd0:    w_rdata_nxt = r_code;
        2'd1:    w_rdata_nxt = r_test_id;
        2'd2:    w_rdata_nxt = {29'd0, r_state};
        default: w_rdata_nxt = w_cycles_ext;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state   <= S_RUNNING;
      r_code    <= 32'd0;
      r_test_id <= 32'd0;
      r_cycles  <= '0;
      r_rdata   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_accept_status)
        r_code <= wdata;
      if (w_wr_testid)
        r_test_id <= wdata;
      if (w_running && (r_cycles != '1))
        r_cycles <= r_cycles + CNT_WIDTH'(1);
    end
  end

  assign rdata   = r_rdata;
  assign state   = r_state;
  assign done    = (r_state != S_RUNNING);
  assign pass    = (r_state == S_PASSED);
  assign code    = r_code;
  assign test_id = r_test_id;
  assign cycles  = r_cycles;

endmodule

// File: tb/tb_test_status_dev.sv
// Directed bench for test_status_dev: default watchdog, a 50-cycle watchdog and a 4-bit
// counter with the watchdog disabled, all sharing one bus.
module tb_test_status_dev;

  localparam logic [29:0] B = 30'h800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  we = '0;
  logic        re = 1'b0;
`ifdef TEST_STATUS_HALT_EN
  logic        halt = 1'b0;
`endif

  logic [31:0] a_rdata, a_code, a_test_id, a_cycles;
  logic        a_sel, a_done, a_pass;
  logic [2:0]  a_state;
  logic [31:0] b_rdata, b_code, b_test_id, b_cycles;
  logic        b_sel, b_done, b_pass;
  logic [2:0]  b_state;
  logic [31:0] c_rdata, c_code, c_test_id;
  logic [3:0]  c_cycles;
  logic        c_sel, c_done, c_pass;
  logic [2:0]  c_state;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  test_status_dev dut_a (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
`ifdef TEST_STATUS_HALT_EN
    .halt(halt),
`endif
    .re(re), .rdata(a_rdata), .sel(a_sel), .state(a_state), .done(a_done), .pass(a_pass),
    .code(a_code), .test_id(a_test_id), .cycles(a_cycles)
  );

  test_status_dev #(.MAX_CYCLES(50)) dut_b (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
`ifdef TEST_STATUS_HALT_EN
    .halt(halt),
`endif
    .re(re), .rdata(b_rdata), .sel(b_sel), .state(b_state), .done(b_done), .pass(b_pass),
    .code(b_code), .test_id(b_test_id), .cycles(b_cycles)
  );

  test_status_dev #(.MAX_CYCLES(0), .CNT_WIDTH(4)) dut_c (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
`ifdef TEST_STATUS_HALT_EN
    .halt(halt),
`endif
    .re(re), .rdata(c_rdata), .sel(c_sel), .state(c_state), .done(c_done), .pass(c_pass),
    .code(c_code), .test_id(c_test_id), .cycles(c_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    addr  = '0;
    wdata = '0;
    we    = '0;
    re    = 1'b0;
  endtask

  task automatic do_reset();
    bus_idle();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // One bus cycle: drive, take one edge, return the bus to idle.
  task automatic bus(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w,
                     input logic r);
    addr  = a;
    wdata = d;
    we    = w;
    re    = r;
    tick(1);
    bus_idle();
  endtask

  initial begin
    // Reset values, sampled while reset is still asserted.
    bus_idle();
    tick(2);
    check("rst_state", a_state, 0);
    check("rst_cycles", a_cycles, 0);
    check("rst_code", a_code, 0);
    check("rst_test_id", a_test_id, 0);
    check("rst_rdata", a_rdata, 0);
    check("rst_done", a_done, 0);
    check("rst_pass", a_pass, 0);
    reset = 1'b0;

    // Pass written when cycles reads 20.
    tick(20);
    check("t1_cycles_pre", a_cycles, 20);
    bus(B, 32'h55, 4'hf, 1'b0);
    check("t1_state", a_state, 1);
    check("t1_done", a_done, 1);
    check("t1_pass", a_pass, 1);
    check("t1_code", a_code, 32'h55);
    check("t1_cycles", a_cycles, 21);
    tick(5);
    check("t1_cycles_frozen", a_cycles, 21);

    // Fail is sticky; TESTID still writable afterwards.
    do_reset();
    bus(B, 32'haa, 4'hf, 1'b0);
    check("t2_state", a_state, 2);
    check("t2_pass", a_pass, 0);
    check("t2_done", a_done, 1);
    bus(B, 32'h55, 4'hf, 1'b0);
    check("t2_sticky_state", a_state, 2);
    check("t2_sticky_code", a_code, 32'haa);
    bus(B + 30'd1, 32'h1234, 4'hf, 1'b0);
    check("t2_test_id", a_test_id, 32'h1234);
    bus(B, 32'h0, 4'h0, 1'b1);
    check("t2_rd_status", a_rdata, 32'haa);
    bus(B + 30'd2, 32'h0, 4'h0, 1'b1);
    check("t2_rd_state", a_rdata, 2);

    // Address decode and back-to-back reads.
    do_reset();
    addr = B + 30'd3; #1 check("t4_sel_top", a_sel, 1);
    addr = B + 30'd4; #1 check("t4_sel_above", a_sel, 0);
    addr = B - 30'd1; #1 check("t4_sel_below", a_sel, 0);
    addr = B;         #1 check("t4_sel_base", a_sel, 1);
    bus_idle();
    bus(B + 30'd1, 32'd7, 4'hf, 1'b0);
    re = 1'b1;
    addr = B + 30'd1; tick(1); check("t4_rd_testid", a_rdata, 7);
    addr = B + 30'd2; tick(1); check("t4_rd_state", a_rdata, 0);
    addr = B + 30'd3; tick(1); check("t4_rd_cycles", a_rdata, 3);
    bus_idle();       tick(1); check("t4_rd_idle", a_rdata, 0);
    bus(30'h10, 32'h0, 4'h0, 1'b1);
    check("t4_rd_ram", a_rdata, 0);
    bus(B, 32'h55, 4'hf, 1'b1);
    check("t4_rd_prewrite", a_rdata, 0);
    check("t4_wr_state", a_state, 1);
    bus(B, 32'h0, 4'h0, 1'b1);
    check("t4_rd_code", a_rdata, 32'h55);

    // Partial and zero STATUS writes are ignored; other codes give ERROR.
    do_reset();
    bus(B, 32'h55, 4'b0011, 1'b0);
    check("t5_partial_state", a_state, 0);
    check("t5_partial_code", a_code, 0);
    bus(B, 32'h0, 4'hf, 1'b0);
    check("t5_zero_state", a_state, 0);
    check("t5_zero_code", a_code, 0);
    bus(B, 32'h33, 4'hf, 1'b0);
    check("t5_err_state", a_state, 3);
    check("t5_err_code", a_code, 32'h33);
    check("t5_err_pass", a_pass, 0);

    // Watchdog at 50 cycles, then pass winning over a same-cycle timeout.
    do_reset();
    tick(49);
    check("t3_state_pre", b_state, 0);
    check("t3_cycles_pre", b_cycles, 49);
    tick(1);
    check("t3_timeout_state", b_state, 4);
    check("t3_timeout_cycles", b_cycles, 50);
    check("t3_timeout_done", b_done, 1);
    tick(3);
    check("t3_cycles_frozen", b_cycles, 50);
    check("t3_state_sticky", b_state, 4);
    do_reset();
    tick(49);
    bus(B, 32'h55, 4'hf, 1'b0);
    check("t3b_state", b_state, 1);
    check("t3b_cycles", b_cycles, 50);

    // 4-bit counter saturates and never times out with MAX_CYCLES=0.
    do_reset();
    tick(20);
    check("sat_cycles", c_cycles, 15);
    check("sat_state", c_state, 0);
    bus(B + 30'd3, 32'h0, 4'h0, 1'b1);
    check("sat_rd_cycles", c_rdata, 15);

`ifdef TEST_STATUS_HALT_EN
    do_reset();
    tick(30);
    halt = 1'b1; tick(1); halt = 1'b0;
    check("t6_state", a_state, 5);
    check("t6_pass", a_pass, 0);
    check("t6_done", a_done, 1);
    check("t6_code", a_code, 0);
    check("t6_cycles", a_cycles, 31);
    tick(9);
    do_reset();
    check("t6_rst_state", a_state, 0);
    check("t6_rst_cycles", a_cycles, 0);
    tick(49);
    halt = 1'b1; tick(1); halt = 1'b0;
    check("t6_halt_over_timeout", b_state, 5);
    do_reset();
    halt = 1'b1;
    bus(B, 32'h55, 4'hf, 1'b0);
    halt = 1'b0;
    check("t6_write_over_halt", a_state, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
